user_adder_wb_core: RTL and testbench

USER_ADDER_WB_CORE -- requirements
Module: user_adder_wb_core

---
 rtl/user_adder_wb_core.sv | 248 ++++++++++++++++++++++++
 tb/tb_user_adder_wb_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/user_adder_wb_core.sv
// ---------------------------------------------------------------------------
// user_adder_wb_core
//
// Wishbone-slave 32-bit adder. Software loads OPA and OPB, then writes START.
// The core adds one 8-bit slice per clock, LSB slice first, and carries
// between slices through a register. After four slices it writes RESULT and
// CARRY and raises DONE. DONE can drive an interrupt.
//
// Register map (offset = wbs_adr_i[7:0]):
//   0x00 CTRL   : bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (R/W)
//   0x04 STATUS : bit0 BUSY (RO), bit1 DONE (W1C), bit2 CARRY (RO)
//   0x08 OPA    : operand A, byte-selectable writes
//   0x0C OPB    : operand B, byte-selectable writes
//   0x10 RESULT : (OPA + OPB) mod 2^32, read-only
//
// Ports:
//   wb_clk_i    : sole clock, rising edge
//   wb_rst_n_i  : asynchronous, active-low reset
//   wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i[3:0],
//   wbs_adr_i[31:0], wbs_dat_i[31:0] : Wishbone slave request
//   wbs_ack_o   : one-cycle transfer acknowledge
//   wbs_dat_o   : registered read data, 0 whenever ack is low
//   irq[2:0]    : irq[0] = DONE & IRQ_EN, irq[2:1] tied to 0
// ---------------------------------------------------------------------------
module user_adder_wb_core #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          SLICE_W   = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  irq
);

    localparam int NUM_SLICES = 32 / SLICE_W;

    localparam logic [7:0] OFS_CTRL   = 8'h00;
    localparam logic [7:0] OFS_STATUS = 8'h04;
    localparam logic [7:0] OFS_OPA    = 8'h08;
    localparam logic [7:0] OFS_OPB    = 8'h0C;
    localparam logic [7:0] OFS_RESULT = 8'h10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ADD  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t      state_q,  state_d;
    logic [1:0]  cnt_q,    cnt_d;
    logic        ack_q,    ack_d;
    logic [31:0] dat_q,    dat_d;
    logic [31:0] opa_q,    opa_d;
    logic [31:0] opb_q,    opb_d;
    logic [31:0] opa_s_q,  opa_s_d;
    logic [31:0] opb_s_q,  opb_s_d;
    logic [31:0] sum_q,    sum_d;
    logic        cin_q,    cin_d;
    logic [31:0] result_q, result_d;
    logic        carry_q,  carry_d;
    logic        done_q,   done_d;
    logic        irq_en_q, irq_en_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        req_sel;
    logic        req_go;
    logic        wr_go;
    logic [7:0]  offset;
    logic        busy;
    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_opa;
    logic        wr_opb;
    logic        start_acc;
    logic        clr_done;
    logic        add_last;
    logic [31:0] byte_mask;
    logic [31:0] rdata;

    assign offset  = wbs_adr_i[7:0];
    assign req_sel = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // A request is serviced only when ack is low, so a held request is
    // acknowledged every other cycle. Writes commit on this same edge.
    assign req_go  = req_sel & ~ack_q;
    assign wr_go   = req_go & wbs_we_i;
    assign busy    = (state_q == S_ADD);

    assign wr_ctrl   = wr_go & (offset == OFS_CTRL)   & wbs_sel_i[0];
    assign wr_status = wr_go & (offset == OFS_STATUS) & wbs_sel_i[0];
    // Operand registers are frozen while an add is in flight.
    assign wr_opa    = wr_go & (offset == OFS_OPA) & ~busy;
    assign wr_opb    = wr_go & (offset == OFS_OPB) & ~busy;

    assign start_acc = wr_ctrl & wbs_dat_i[0] & ~busy;
    assign clr_done  = wr_status & wbs_dat_i[1];
    assign add_last  = busy & (cnt_q == 2'd3);

    // Expand byte selects into a 32-bit write mask.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign byte_mask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end

    // ------------------------------------------------------------------
    // Slice datapath: split the snapshots into slices and add the
    // slice selected by the counter together with the registered carry.
    // ------------------------------------------------------------------
    logic [SLICE_W-1:0] a_slice [NUM_SLICES];
    logic [SLICE_W-1:0] b_slice [NUM_SLICES];
    logic [SLICE_W:0]   slice_sum;

    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
        assign a_slice[gi] = opa_s_q[gi*SLICE_W +: SLICE_W];
        assign b_slice[gi] = opb_s_q[gi*SLICE_W +: SLICE_W];
    end

    assign slice_sum = {1'b0, a_slice[cnt_q]} + {1'b0, b_slice[cnt_q]}
                     + {{SLICE_W{1'b0}}, cin_q};

    // ------------------------------------------------------------------
    // Read mux (values as they stand before the acknowledging edge)
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 32'h0;
        case (offset)
            OFS_CTRL:   rdata = {30'h0, irq_en_q, 1'b0};
            OFS_STATUS: rdata = {29'h0, carry_q, done_q, busy};
            OFS_OPA:    rdata = opa_q;
            OFS_OPB:    rdata = opb_q;
            OFS_RESULT: rdata = result_q;
            default:    rdata = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic: FSM, datapath and register file
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = req_go;
        dat_d    = (req_go & ~wbs_we_i) ? rdata : 32'h0;
        opa_d    = opa_q;
        opb_d    = opb_q;
        opa_s_d  = opa_s_q;
        opb_s_d  = opb_s_q;
        sum_d    = sum_q;
        cin_d    = cin_q;
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = done_q;
        irq_en_d = irq_en_q;

        if (wr_opa) begin
            opa_d = (opa_q & ~byte_mask) | (wbs_dat_i & byte_mask);
        end
        if (wr_opb) begin
            opb_d = (opb_q & ~byte_mask) | (wbs_dat_i & byte_mask);
        end
        if (wr_ctrl) begin
            irq_en_d = wbs_dat_i[1];
        end
        if (clr_done) begin
            done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    state_d = S_ADD;
                    opa_s_d = opa_q;
                    opb_s_d = opb_q;
                    cin_d   = 1'b0;
                    cnt_d   = 2'd0;
                    done_d  = 1'b0;
                end
            end
            S_ADD: begin
                sum_d[cnt_q*SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
                cin_d = slice_sum[SLICE_W];
                cnt_d = cnt_q + 2'd1;
                if (add_last) begin
                    state_d  = S_IDLE;
                    cnt_d    = 2'd0;
                    result_d = sum_d;
                    carry_d  = slice_sum[SLICE_W];
                    // Completion wins over a simultaneous W1C clear.
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            ack_q    <= 1'b0;
            dat_q    <= 32'h0;
            opa_q    <= 32'h0;
            opb_q    <= 32'h0;
            opa_s_q  <= 32'h0;
            opb_s_q  <= 32'h0;
            sum_q    <= 32'h0;
            cin_q    <= 1'b0;
            result_q <= 32'h0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            opa_s_q  <= opa_s_d;
            opb_s_q  <= opb_s_d;
            sum_q    <= sum_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = {2'b00, done_q & irq_en_q};

endmodule

// File: tb/tb_user_adder_wb_core.sv
// ---------------------------------------------------------------------------
// tb_user_adder_wb_core
//
// Directed self-checking bench for user_adder_wb_core. Read expectations are
// pushed to a scoreboard queue when a read is issued and popped when the
// acknowledge arrives. One line is printed per bus transaction.
// ---------------------------------------------------------------------------
module tb_user_adder_wb_core;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] CTRL   = BASE + 32'h00;
    localparam logic [31:0] STATUS = BASE + 32'h04;
    localparam logic [31:0] OPA    = BASE + 32'h08;
    localparam logic [31:0] OPB    = BASE + 32'h0C;
    localparam logic [31:0] RESULT = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [2:0]  irq;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    user_adder_wb_core #(
        .BASE_ADDR (32'h3000_0000),
        .SLICE_W   (8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer; waits a bounded number of cycles for ack.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic acked);
        stb  = 1'b1;
        cyc  = 1'b1;
        we   = w;
        adr  = a;
        wdat = d;
        sel  = s;
        acked = 1'b0;
        rd    = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                acked = 1'b1;
                rd    = rdat;
                break;
            end
        end
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        $display("[TB] %s adr=0x%08h dat=0x%08h sel=%b ack=%0d rdata=0x%08h",
                 w ? "WR" : "RD", a, d, s, acked, rd);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input string tag);
        logic [31:0] rd;
        logic        acked;
        wb_xfer(1'b1, a, d, s, rd, acked);
        check({tag, "_ack"}, {31'h0, acked}, 32'h1);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic        acked;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        wb_xfer(1'b0, a, 32'h0, 4'hF, rd, acked);
        if (!acked) begin
            check({tag_q.pop_front(), "_ack"}, 32'h0, 32'h1);
            void'(exp_q.pop_front());
        end else begin
            check(tag_q.pop_front(), rd, exp_q.pop_front());
        end
    endtask

    // Poll STATUS until BUSY clears, bounded.
    task automatic wait_done(input string tag);
        logic [31:0] rd;
        logic        acked;
        logic        seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wb_xfer(1'b0, STATUS, 32'h0, 4'hF, rd, acked);
            if (acked && rd[0] == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'h0, seen}, 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        acked;
        int          cnt;

        // ---------------- Reset ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_irq", {29'h0, irq}, 32'h0);
        rst_n = 1'b1;
        wb_read(CTRL,   32'h0, "rst_ctrl");
        wb_read(STATUS, 32'h0, "rst_status");
        wb_read(OPA,    32'h0, "rst_opa");
        wb_read(OPB,    32'h0, "rst_opb");
        wb_read(RESULT, 32'h0, "rst_result");

        // ---------------- 5 + 7 ----------------
        wb_write(OPA,  32'h0000_0005, 4'hF, "t1_opa");
        wb_write(OPB,  32'h0000_0007, 4'hF, "t1_opb");
        wb_write(CTRL, 32'h0000_0001, 4'hF, "t1_start");
        repeat (3) @(posedge clk);
        #1;
        // Acks on the 4th edge after START: still reports the busy state.
        wb_read(STATUS, 32'h0000_0001, "t1_busy_e4");
        wb_read(STATUS, 32'h0000_0002, "t1_done");
        wb_read(RESULT, 32'h0000_000C, "t1_result");
        check("t1_irq_off", {29'h0, irq}, 32'h0);

        // ---------------- carry ripple ----------------
        wb_write(OPA,  32'hFFFF_FFFF, 4'hF, "t2_opa");
        wb_write(OPB,  32'h0000_0001, 4'hF, "t2_opb");
        wb_write(CTRL, 32'h0000_0001, 4'hF, "t2_start");
        wait_done("t2_wait");
        wb_read(RESULT, 32'h0000_0000, "t2_result");
        wb_read(STATUS, 32'h0000_0006, "t2_status");

        // ---------------- IRQ and exact latency ----------------
        wb_write(CTRL, 32'h0000_0003, 4'hF, "t3_start");
        check("t3_irq_start", {29'h0, irq}, 32'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (irq[0]) break;
        end
        check("t3_latency", cnt, 32'd4);
        check("t3_irq_on", {29'h0, irq}, 32'h1);
        wb_read(CTRL, 32'h0000_0002, "t3_ctrl");
        wb_write(STATUS, 32'h0000_0002, 4'hF, "t3_w1c");
        check("t3_irq_clr", {29'h0, irq}, 32'h0);
        wb_read(STATUS, 32'h0000_0004, "t3_status");

        // ---------------- writes during BUSY ----------------
        wb_write(OPA,  32'h0000_0010, 4'hF, "t4_opa");
        wb_write(OPB,  32'h0000_0020, 4'hF, "t4_opb");
        wb_write(CTRL, 32'h0000_0001, 4'hF, "t4_start");
        wb_write(OPB,  32'h1234_5678, 4'hF, "t4_busy_opb");
        wb_write(CTRL, 32'h0000_0001, 4'hF, "t4_busy_start");
        wait_done("t4_wait");
        wb_write(STATUS, 32'h0000_0002, 4'hF, "t4_w1c");
        repeat (8) @(posedge clk);
        #1;
        wb_read(STATUS, 32'h0000_0000, "t4_single_done");
        wb_read(RESULT, 32'h0000_0030, "t4_result");
        wb_read(OPB,    32'h0000_0020, "t4_opb_kept");

        // ---------------- byte selects and decode ----------------
        wb_write(OPA, 32'h0000_0000, 4'hF, "t5_opa_clr");
        wb_write(OPA, 32'hAABB_CCDD, 4'b0101, "t5_opa_sel");
        wb_read(OPA, 32'h00BB_00DD, "t5_opa");
        wb_read(BASE + 32'h20, 32'h0, "t5_unmapped");
        wb_write(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, "t5_unmapped_wr");
        wb_read(OPA, 32'h00BB_00DD, "t5_opa_kept");
        wb_xfer(1'b0, 32'h3001_0000, 32'h0, 4'hF, rd, acked);
        check("t5_noack", {31'h0, acked}, 32'h0);

        // ---------------- held request: ack every other cycle ----------------
        stb = 1'b1;
        cyc = 1'b1;
        we  = 1'b0;
        adr = OPA;
        sel = 4'hF;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack) cnt++;
        end
        stb = 1'b0;
        cyc = 1'b0;
        $display("[TB] RD held 4 cycles adr=0x%08h acks=%0d", OPA, cnt);
        check("t6_b2b_acks", cnt, 32'd2);
        @(posedge clk);
        #1;

        // ---------------- reset mid-ADD ----------------
        wb_write(OPA,  32'h0000_0010, 4'hF, "t7_opa");
        wb_write(OPB,  32'h0000_0020, 4'hF, "t7_opb");
        wb_write(CTRL, 32'h0000_0003, 4'hF, "t7_start");
        wb_read(STATUS, 32'h0000_0001, "t7_busy");
        rst_n = 1'b0;
        #1;
        check("t7_rst_ack", {31'h0, ack}, 32'h0);
        check("t7_rst_dat", rdat, 32'h0);
        check("t7_rst_irq", {29'h0, irq}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wb_read(STATUS, 32'h0, "t7_status");
        wb_read(RESULT, 32'h0, "t7_result");
        wb_read(CTRL,   32'h0, "t7_ctrl");
        repeat (8) @(posedge clk);
        #1;
        wb_read(STATUS, 32'h0, "t7_status_late");
        check("t7_irq_late", {29'h0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
